// File: rtl/key_scan_pkg.sv
// Shared definitions for the key_scan front end: hold-FSM encoding and
// counter-width helpers used to size the per-channel counters.
package key_scan_pkg;

    typedef enum logic [1:0] {
        ST_REL  = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } hold_state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Never return a zero-width counter, even for degenerate parameters.
    function automatic int cnt_width(input int value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/key_scan_if.sv
// Key pin and event bundle between the board pins and the control logic.
interface key_scan_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;
    logic [N_KEYS-1:0] key_repeat;

    modport master (
        output key_in,
        input  key_level, key_press, key_release, key_long, key_repeat
    );

    modport slave (
        input  key_in,
        output key_level, key_press, key_release, key_long, key_repeat
    );
endinterface

// File: rtl/key_chan.sv
// One key channel: cycle-exact debouncer, edge pulses and the
// REL/HELD/LONG hold machine driven by the shared millisecond tick.
module key_chan
    import key_scan_pkg::*;
#(
    parameter int DEB_CYC   = 240000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int REPEAT_EN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic pressed,
    input  logic tick,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam int DEB_W  = cnt_width(DEB_CYC + 1);
    localparam int HOLD_W = cnt_width(LONG_MS + 1);
    localparam int REP_W  = cnt_width(REPEAT_MS + 1);

    localparam logic [DEB_W-1:0]  DEB_ZERO  = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_MS);
    localparam logic [REP_W-1:0]  REP_ZERO  = {REP_W{1'b0}};
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_MS - 1);
    localparam logic              REP_ENABLE = (REPEAT_EN != 0);

    logic [DEB_W-1:0]  deb_cnt_r, deb_cnt_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
    logic [REP_W-1:0]  rep_cnt_r, rep_cnt_s;
    hold_state_t       state_r, state_s;
    logic              toggle_s, press_evt_s, release_evt_s;
    logic              long_s, repeat_s;
    logic              level_r, press_r, release_r, long_r, repeat_r;

    // Debounce: count consecutive samples disagreeing with the accepted level.
    always_comb begin
        deb_cnt_s = deb_cnt_r;
        toggle_s  = 1'b0;
        if (pressed == level_r) begin
            deb_cnt_s = DEB_ZERO;
        end else if (deb_cnt_r >= DEB_LAST) begin
            deb_cnt_s = DEB_ZERO;
            toggle_s  = 1'b1;
        end else begin
            deb_cnt_s = deb_cnt_r + DEB_ONE;
        end
    end

    assign press_evt_s   = toggle_s & ~level_r;
    assign release_evt_s = toggle_s & level_r;

    // Hold machine next state; an accepted release overrides any tick action.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        rep_cnt_s  = rep_cnt_r;
        long_s     = 1'b0;
        repeat_s   = 1'b0;
        if (release_evt_s) begin
            state_s = ST_REL;
        end else begin
            case (state_r)
                ST_REL: begin
                    if (press_evt_s) begin
                        state_s    = ST_HELD;
                        hold_cnt_s = HOLD_ZERO;
                    end else begin
                        state_s = ST_REL;
                    end
                end
                ST_HELD: begin
                    if (!tick) begin
                        state_s = ST_HELD;
                    end else if (hold_cnt_r >= HOLD_LAST) begin
                        hold_cnt_s = HOLD_SAT;
                        rep_cnt_s  = REP_ZERO;
                        long_s     = 1'b1;
                        state_s    = ST_LONG;
                    end else begin
                        hold_cnt_s = hold_cnt_r + HOLD_ONE;
                    end
                end
                ST_LONG: begin
                    if (!tick) begin
                        state_s = ST_LONG;
                    end else if (rep_cnt_r >= REP_LAST) begin
                        rep_cnt_s = REP_ZERO;
                        repeat_s  = REP_ENABLE;
                    end else begin
                        rep_cnt_s = rep_cnt_r + REP_ONE;
                    end
                end
                default: begin
                    state_s = ST_REL;
                end
            endcase
        end
    end

    // Debounce counter, accepted level and press/release pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt_r <= DEB_ZERO;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            deb_cnt_r <= deb_cnt_s;
            level_r   <= level_r ^ toggle_s;
            press_r   <= press_evt_s;
            release_r <= release_evt_s;
        end
    end

    // Hold machine state, hold/repeat counters and long/repeat pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_REL;
            hold_cnt_r <= HOLD_ZERO;
            rep_cnt_r  <= REP_ZERO;
            long_r     <= 1'b0;
            repeat_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            rep_cnt_r  <= rep_cnt_s;
            long_r     <= long_s;
            repeat_r   <= repeat_s;
        end
    end

    assign key_level   = level_r;
    assign key_press   = press_r;
    assign key_release = release_r;
    assign key_long    = long_r;
    assign key_repeat  = repeat_r;

endmodule

// File: rtl/key_scan.sv
// Multi-key front end: two-flop pin synchronisers, one shared hold tick
// and an array of independent key_chan channels.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int N_KEYS    = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int DEB_CYC   = 240000,
    parameter int TICK_CYC  = 12000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int REPEAT_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    key_scan_if.slave  bus
);

    localparam int TICK_W = cnt_width(TICK_CYC);
    localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
    localparam logic [N_KEYS-1:0] IDLE_PIN  =
        (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    logic [N_KEYS-1:0] sync1_r, sync2_r, pressed_s;
    logic [N_KEYS-1:0] level_s, press_s, release_s, long_s, repeat_s;
    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_r;

    // Pin synchronisers, parked at the released level while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= IDLE_PIN;
            sync2_r <= IDLE_PIN;
        end else begin
            sync1_r <= bus.key_in;
            sync2_r <= sync1_r;
        end
    end

    assign pressed_s = sync2_r ^ IDLE_PIN;

    // Free-running prescaler producing the one-cycle hold tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_r <= TICK_ZERO;
            tick_r     <= 1'b0;
        end else begin
            if (tick_cnt_r >= TICK_LAST) begin
                tick_cnt_r <= TICK_ZERO;
            end else begin
                tick_cnt_r <= tick_cnt_r + TICK_ONE;
            end
            tick_r <= (tick_cnt_r >= TICK_LAST);
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_chan #(
            .DEB_CYC   (DEB_CYC),
            .LONG_MS   (LONG_MS),
            .REPEAT_MS (REPEAT_MS),
            .REPEAT_EN (REPEAT_EN)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .pressed     (pressed_s[i]),
            .tick        (tick_r),
            .key_level   (level_s[i]),
            .key_press   (press_s[i]),
            .key_release (release_s[i]),
            .key_long    (long_s[i]),
            .key_repeat  (repeat_s[i])
        );
    end

    assign bus.key_level   = level_s;
    assign bus.key_press   = press_s;
    assign bus.key_release = release_s;
    assign bus.key_long    = long_s;
    assign bus.key_repeat  = repeat_s;

endmodule
